// File: rtl/matmul_controller.sv
`default_nettype none
// ============================================================================
// Module   : matmul_controller
// Purpose  : Sequences one C = A x B product through a single shared
//            multiplier, accumulating inner products and writing each C element.
// Revision : 1.0 - initial release
// ============================================================================
module matmul_controller #(
  parameter int A_ROWS     = 8,
  parameter int INNER_DIM  = 8,
  parameter int B_COLUMNS  = 8,
  parameter int DATA_WIDTH = 32,
  localparam int AW_A = (A_ROWS * INNER_DIM > 1) ? $clog2(A_ROWS * INNER_DIM) : 1,
  localparam int AW_B = (INNER_DIM * B_COLUMNS > 1) ? $clog2(INNER_DIM * B_COLUMNS) : 1,
  localparam int AW_C = (A_ROWS * B_COLUMNS > 1) ? $clog2(A_ROWS * B_COLUMNS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [AW_A-1:0]       rd_address_a,
  input  logic [DATA_WIDTH-1:0] read_data_a,
  output logic [AW_B-1:0]       rd_address_b,
  input  logic [DATA_WIDTH-1:0] read_data_b,
  output logic [DATA_WIDTH-1:0] mult_a,
  output logic [DATA_WIDTH-1:0] mult_b,
  output logic                  mult_start,
  input  logic [DATA_WIDTH-1:0] mult_out,
  input  logic                  mult_done,
  output logic [AW_C-1:0]       wr_address_c,
  output logic [DATA_WIDTH-1:0] wr_data_c,
  output logic                  wr_en_c
);

  localparam int IW = (A_ROWS > 1) ? $clog2(A_ROWS) : 1;
  localparam int KW = (INNER_DIM > 1) ? $clog2(INNER_DIM) : 1;
  localparam int JW = (B_COLUMNS > 1) ? $clog2(B_COLUMNS) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(A_ROWS - 1);
  localparam logic [KW-1:0] K_LAST = KW'(INNER_DIM - 1);
  localparam logic [JW-1:0] J_LAST = JW'(B_COLUMNS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_MWAIT = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                r_state;
  logic [IW-1:0]         r_row;
  logic [KW-1:0]         r_k;
  logic [JW-1:0]         r_col;
  logic [DATA_WIDTH-1:0] r_acc;

  logic [DATA_WIDTH-1:0] w_sum;
  logic [KW-1:0]         w_k_next;
  logic [JW-1:0]         w_col_next;
  logic [IW-1:0]         w_row_next;
  logic                  w_last_elem;

  function automatic logic [AW_A-1:0] addr_a(input logic [IW-1:0] row, input logic [KW-1:0] kk);
    return AW_A'(32'(row) * 32'(INNER_DIM) + 32'(kk));
  endfunction

  function automatic logic [AW_B-1:0] addr_b(input logic [KW-1:0] kk, input logic [JW-1:0] col);
    return AW_B'(32'(kk) * 32'(B_COLUMNS) + 32'(col));
  endfunction

  function automatic logic [AW_C-1:0] addr_c(input logic [IW-1:0] row, input logic [JW-1:0] col);
    return AW_C'(32'(row) * 32'(B_COLUMNS) + 32'(col));
  endfunction

  always_comb begin
    w_sum       = r_acc + mult_out;
    w_k_next    = r_k + 1'b1;
    w_col_next  = (r_col == J_LAST) ? '0 : r_col + 1'b1;
    w_row_next  = (r_col == J_LAST) ? r_row + 1'b1 : r_row;
    w_last_elem = (r_row == I_LAST) && (r_col == J_LAST);
  end

  // Read addresses are loaded on the edge entering FETCH so they are stable for the whole FETCH cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_k          <= '0;
      r_col        <= '0;
      r_acc        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rd_address_a <= '0;
      rd_address_b <= '0;
      mult_a       <= '0;
      mult_b       <= '0;
      mult_start   <= 1'b0;
      wr_address_c <= '0;
      wr_data_c    <= '0;
      wr_en_c      <= 1'b0;
    end else begin
      mult_start <= 1'b0;
      wr_en_c    <= 1'b0;
      done       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_FETCH;
            busy         <= 1'b1;
            r_row        <= '0;
            r_k          <= '0;
            r_col        <= '0;
            r_acc        <= '0;
            rd_address_a <= '0;
            rd_address_b <= '0;
          end
        end
        S_FETCH: begin
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          mult_a     <= read_data_a;
          mult_b     <= read_data_b;
          mult_start <= 1'b1;
          r_state    <= S_MWAIT;
        end
        S_MWAIT: begin
          // mult_start is high only in the first MWAIT cycle; a done coincident with it is not a product.
          if (mult_done && !mult_start) begin
            r_acc <= w_sum;
            if (r_k == K_LAST) begin
              wr_data_c    <= w_sum;
              wr_address_c <= addr_c(r_row, r_col);
              wr_en_c      <= 1'b1;
              r_state      <= S_WRITE;
            end else begin
              r_k          <= w_k_next;
              rd_address_a <= addr_a(r_row, w_k_next);
              rd_address_b <= addr_b(w_k_next, r_col);
              r_state      <= S_FETCH;
            end
          end
        end
        S_WRITE: begin
          r_acc <= '0;
          r_k   <= '0;
          if (w_last_elem) begin
            r_row   <= '0;
            r_col   <= '0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_row        <= w_row_next;
            r_col        <= w_col_next;
            rd_address_a <= addr_a(w_row_next, '0);
            rd_address_b <= addr_b('0, w_col_next);
            r_state      <= S_FETCH;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matmul_controller.sv
`default_nettype none
// Bench for matmul_controller: table-driven 2x2x2 vectors on a small instance and
// randomized 8x8x8 products on a default instance, compared against a plain matrix product.
module tb_matmul_controller;
  localparam int N     = 8;
  localparam int NN    = N * N;
  localparam int LIMIT = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, s_start;

  logic        busy, done, mult_start, mult_done, wr_en_c;
  logic [5:0]  rd_address_a, rd_address_b, wr_address_c;
  logic [31:0] read_data_a, read_data_b, mult_a, mult_b, mult_out, wr_data_c;

  logic        s_busy, s_done, s_mult_start, s_mult_done, s_wr_en_c;
  logic [1:0]  s_rd_address_a, s_rd_address_b, s_wr_address_c;
  logic [31:0] s_read_data_a, s_read_data_b, s_mult_a, s_mult_b, s_mult_out, s_wr_data_c;

  matmul_controller u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_address_a(rd_address_a), .read_data_a(read_data_a),
    .rd_address_b(rd_address_b), .read_data_b(read_data_b),
    .mult_a(mult_a), .mult_b(mult_b), .mult_start(mult_start),
    .mult_out(mult_out), .mult_done(mult_done),
    .wr_address_c(wr_address_c), .wr_data_c(wr_data_c), .wr_en_c(wr_en_c)
  );

  matmul_controller #(.A_ROWS(2), .INNER_DIM(2), .B_COLUMNS(2), .DATA_WIDTH(32)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
    .rd_address_a(s_rd_address_a), .read_data_a(s_read_data_a),
    .rd_address_b(s_rd_address_b), .read_data_b(s_read_data_b),
    .mult_a(s_mult_a), .mult_b(s_mult_b), .mult_start(s_mult_start),
    .mult_out(s_mult_out), .mult_done(s_mult_done),
    .wr_address_c(s_wr_address_c), .wr_data_c(s_wr_data_c), .wr_en_c(s_wr_en_c)
  );

  // Memories with one-cycle read latency
  logic [31:0] mem_a [NN];
  logic [31:0] mem_b [NN];
  logic [31:0] ref_c [NN];
  logic [31:0] s_mem_a [4];
  logic [31:0] s_mem_b [4];

  always @(posedge clk) begin
    read_data_a   <= mem_a[rd_address_a];
    read_data_b   <= mem_b[rd_address_b];
    s_read_data_a <= s_mem_a[s_rd_address_a];
    s_read_data_b <= s_mem_b[s_rd_address_b];
  end

  // Multiplier models: small instance fixed one-cycle latency, main instance configurable
  always @(posedge clk) begin
    s_mult_done <= s_mult_start;
    s_mult_out  <= s_mult_a * s_mult_b;
  end

  int          lat_cfg = 1;
  int          pend = 0;
  int          lat = 1;
  logic        mdl_done = 1'b0;
  logic [31:0] mdl_out = '0;
  logic [31:0] prod = '0;
  logic        manual, man_done;
  logic [31:0] man_out;

  always @(posedge clk) begin
    mdl_done <= 1'b0;
    if (mult_start) begin
      lat = (lat_cfg == 0) ? int'($urandom_range(1, 5)) : lat_cfg;
      if (lat == 1) begin
        mdl_done <= 1'b1;
        mdl_out  <= mult_a * mult_b;
        pend     <= 0;
      end else begin
        pend <= lat - 1;
        prod <= mult_a * mult_b;
      end
    end else if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1) begin
        mdl_done <= 1'b1;
        mdl_out  <= prod;
      end
    end
  end

  assign mult_done = manual ? man_done : mdl_done;
  assign mult_out  = manual ? man_out  : mdl_out;

  // Monitors
  int          cyc_cnt = 0;
  int          done_cnt = 0, ms_cnt = 0, s_done_cnt = 0, s_done_cyc = 0;
  int          waddr_q [$];
  logic [31:0] wdata_q [$];
  int          s_waddr_q [$];
  logic [31:0] s_wdata_q [$];
  int          s_wcyc_q [$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (wr_en_c) begin
      waddr_q.push_back(int'(wr_address_c));
      wdata_q.push_back(wr_data_c);
    end
    if (done) done_cnt++;
    if (mult_start) ms_cnt++;
    if (s_wr_en_c) begin
      s_waddr_q.push_back(int'(s_wr_address_c));
      s_wdata_q.push_back(s_wr_data_c);
      s_wcyc_q.push_back(cyc_cnt);
    end
    if (s_done) begin
      s_done_cnt++;
      s_done_cyc = cyc_cnt;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic compute_ref();
    logic [31:0] sum;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        sum = '0;
        for (int k = 0; k < N; k++) sum = sum + mem_a[r*N+k] * mem_b[k*N+c];
        ref_c[r*N+c] = sum;
      end
    end
  endtask

  task automatic fill_random();
    for (int x = 0; x < NN; x++) begin
      mem_a[x] = $urandom();
      mem_b[x] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < LIMIT) begin
      step();
      n++;
    end
    check({tag, "_done_seen"}, done, 1);
  endtask

  task automatic compare_writes(input int base, input string tag);
    for (int idx = 0; idx < NN; idx++) begin
      if (base + idx < waddr_q.size()) begin
        check($sformatf("%s_addr%0d", tag, idx), waddr_q[base+idx], idx);
        check($sformatf("%s_data%0d", tag, idx), wdata_q[base+idx], ref_c[idx]);
      end
    end
  endtask

  task automatic run_main(input string tag);
    int base, dbase;
    compute_ref();
    base  = waddr_q.size();
    dbase = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(tag);
    step();
    check({tag, "_done_pulses"}, done_cnt - dbase, 1);
    check({tag, "_write_count"}, waddr_q.size() - base, NN);
    check({tag, "_busy_idle"}, busy, 0);
    compare_writes(base, tag);
  endtask

  typedef struct packed {
    logic [3:0][31:0] a;
    logic [3:0][31:0] b;
    logic [3:0][31:0] c;
    int               cycles;
  } vec_t;

  vec_t vecs [3];

  task automatic run_small(input int v);
    int n, base, dbase;
    for (int x = 0; x < 4; x++) begin
      s_mem_a[x] = vecs[v].a[x];
      s_mem_b[x] = vecs[v].b[x];
    end
    base    = s_waddr_q.size();
    dbase   = s_done_cnt;
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    n = 1;
    while (s_done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check($sformatf("v%0d_cycles", v), n, vecs[v].cycles);
    if (s_wcyc_q.size() > 0)
      check($sformatf("v%0d_write_to_done", v), s_done_cyc - s_wcyc_q[$], 1);
    step();
    check($sformatf("v%0d_write_count", v), s_waddr_q.size() - base, 4);
    check($sformatf("v%0d_done_pulses", v), s_done_cnt - dbase, 1);
    check($sformatf("v%0d_busy_idle", v), s_busy, 0);
    for (int x = 0; x < 4; x++) begin
      if (base + x < s_waddr_q.size()) begin
        check($sformatf("v%0d_addr%0d", v, x), s_waddr_q[base+x], x);
        check($sformatf("v%0d_data%0d", v, x), s_wdata_q[base+x], vecs[v].c[x]);
      end
    end
  endtask

  initial begin
    int base, dbase, msbase, n;
    rst = 1'b1; start = 1'b0; s_start = 1'b0;
    manual = 1'b0; man_done = 1'b0; man_out = '0; lat_cfg = 1;
    for (int x = 0; x < NN; x++) begin mem_a[x] = '0; mem_b[x] = '0; end
    for (int x = 0; x < 4; x++) begin s_mem_a[x] = '0; s_mem_b[x] = '0; end

    vecs[0].a = {32'd4, 32'd3, 32'd2, 32'd1};
    vecs[0].b = {32'd8, 32'd7, 32'd6, 32'd5};
    vecs[0].c = {32'd50, 32'd43, 32'd22, 32'd19};
    vecs[0].cycles = 37;
    vecs[1].a = {32'd0, 32'd0, 32'd1, 32'hFFFF_FFFF};
    vecs[1].b = {32'd0, 32'd3, 32'd0, 32'd2};
    vecs[1].c = {32'd0, 32'd0, 32'd0, 32'd1};
    vecs[1].cycles = 37;
    vecs[2].a = {32'd2, 32'd0, 32'd0, 32'd2};
    vecs[2].b = {32'd6, 32'd7, 32'd8, 32'd9};
    vecs[2].c = {32'd12, 32'd14, 32'd16, 32'd18};
    vecs[2].cycles = 37;

    repeat (3) step();
    check("reset_main_outputs", |{busy, done, rd_address_a, rd_address_b, mult_a, mult_b,
                                   mult_start, wr_address_c, wr_data_c, wr_en_c}, 0);
    check("reset_small_outputs", |{s_busy, s_done, s_rd_address_a, s_rd_address_b, s_mult_a, s_mult_b,
                                    s_mult_start, s_wr_address_c, s_wr_data_c, s_wr_en_c}, 0);
    rst = 1'b0;
    step();
    check("idle_busy", busy, 0);

    for (int v = 0; v < 3; v++) run_small(v);

    // Identity A times counting B
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        mem_a[r*N+c] = (r == c) ? 32'd1 : 32'd0;
        mem_b[r*N+c] = 32'(r * N + c);
      end
    lat_cfg = 0;
    run_main("ident");

    for (int t = 0; t < 2; t++) begin
      fill_random();
      run_main($sformatf("rand%0d", t));
    end

    // start pulsed in FETCH, MWAIT and DONE must not restart
    fill_random();
    compute_ref();
    lat_cfg = 1;
    base  = waddr_q.size();
    dbase = done_cnt;
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    n = 0;
    while (mult_start !== 1'b1 && n < 20) begin step(); n++; end
    check("abuse_ms_seen", mult_start, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("abuse");
    start = 1'b1;
    step();
    start = 1'b0;
    check("abuse_idle_after_done", busy, 0);
    step();
    check("abuse_stays_idle", busy, 0);
    check("abuse_done_pulses", done_cnt - dbase, 1);
    check("abuse_write_count", waddr_q.size() - base, NN);
    compare_writes(base, "abuse");

    // start held high across DONE relaunches in IDLE
    base  = waddr_q.size();
    dbase = done_cnt;
    start = 1'b1;
    step();
    wait_done("held1");
    step();
    check("held_idle_cycle", busy, 0);
    step();
    check("held_relaunch_busy", busy, 1);
    start = 1'b0;
    wait_done("held2");
    step();
    check("held_done_pulses", done_cnt - dbase, 2);
    check("held_write_count", waddr_q.size() - base, 2 * NN);
    compare_writes(base, "held1");
    compare_writes(base + NN, "held2");

    // Reset in MWAIT of element (1,0), multiplier answers afterwards
    fill_random();
    lat_cfg = 1;
    base   = waddr_q.size();
    start  = 1'b1;
    step();
    start  = 1'b0;
    n = 0;
    while (!(mult_start === 1'b1 && waddr_q.size() - base == N) && n < LIMIT) begin step(); n++; end
    check("rst_mid_reached", mult_start, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    msbase = ms_cnt;
    check("rst_mid_outputs", |{busy, done, rd_address_a, rd_address_b, mult_a, mult_b,
                                mult_start, wr_address_c, wr_data_c, wr_en_c}, 0);
    repeat (10) step();
    check("rst_mid_no_writes", waddr_q.size() - base, N);
    check("rst_mid_no_mult_start", ms_cnt - msbase, 0);
    check("rst_mid_idle", busy, 0);
    lat_cfg = 0;
    run_main("after_rst");

    // mult_done coincident with mult_start, then stuck low
    fill_random();
    compute_ref();
    manual = 1'b1;
    base   = waddr_q.size();
    msbase = ms_cnt;
    start  = 1'b1;
    step();
    start  = 1'b0;
    n = 0;
    while (mult_start !== 1'b1 && n < 20) begin step(); n++; end
    check("stuck_ms_seen", mult_start, 1);
    man_done = 1'b1;
    man_out  = 32'hDEAD_BEEF;
    step();
    man_done = 1'b0;
    repeat (20) step();
    check("stuck_busy", busy, 1);
    check("stuck_no_advance", rd_address_a, 0);
    check("stuck_one_start", ms_cnt - msbase, 1);
    check("stuck_no_write", waddr_q.size() - base, 0);
    man_out  = mult_a * mult_b;
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    manual   = 1'b0;
    wait_done("stuck");
    step();
    check("stuck_write_count", waddr_q.size() - base, NN);
    compare_writes(base, "stuck");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
